// File: rtl/serial_to_parallel_sync_pkg.sv
// Shared link definitions for the serial transmit and receive paths.
// Holds word width, the comma idle symbol, lock depth and receiver state encodings.
// Contains no logic. The serializer and deserializer both import it so the two ends agree.
package serial_to_parallel_sync_pkg;

   localparam int               DATA_W     = 8;
   localparam logic [7:0]       COMMA      = 8'hBC;
   localparam int               LOCK_COUNT = 4;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_to_parallel_sync.sv
// Serial-to-parallel converter with comma alignment. Recovers DATA_W-bit words, MSB first.
// Latency: data_out, valid_out and byte_strobe update one edge after a word's last bit is sampled.
// Backpressure: none. The link free-runs, and one word is presented every DATA_W cycles once locked.
module serial_to_parallel_sync #(
   parameter int                DATA_W     = serial_to_parallel_sync_pkg::DATA_W,
   parameter logic [DATA_W-1:0] COMMA      = serial_to_parallel_sync_pkg::COMMA,
   parameter int                LOCK_COUNT = serial_to_parallel_sync_pkg::LOCK_COUNT
) (
   input  logic              clk8f,
   input  logic              reset,
   input  logic              data_serial,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              byte_strobe,
   output logic              active
);
   import serial_to_parallel_sync_pkg::*;

   localparam int BW = $clog2(DATA_W);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic [CW-1:0] LOCK_TGT = CW'(LOCK_COUNT);

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] sh;
   logic [BW-1:0]     bit_cnt;
   logic [BW-1:0]     bit_nxt;
   logic [CW-1:0]     comma_cnt;
   logic [CW-1:0]     comma_nxt;
   logic [CW-1:0]     comma_inc;
   logic              boundary;
   logic              is_comma;
   logic              word_upd;

   assign boundary  = (bit_cnt == '0);
   assign is_comma  = (sh == COMMA);
   assign comma_inc = comma_cnt + CW'(1);
   assign active    = (state == ACTIVE);

   // Next-state logic. In HUNT a comma at any bit offset re-phases the bit counter.
   // LOCKING only looks at word boundaries. ACTIVE never leaves except through reset.
   always_comb begin
      state_nxt = state;
      comma_nxt = comma_cnt;
      bit_nxt   = bit_cnt + BW'(1);
      word_upd  = 1'b0;
      case (state)
         HUNT: begin
            if (is_comma) begin
               // The edge that sees the comma acts as boundary 0, so the count restarts at 1.
               bit_nxt   = BW'(1);
               comma_nxt = CW'(1);
               state_nxt = (LOCK_COUNT == 1) ? ACTIVE : LOCKING;
            end
         end
         LOCKING: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_nxt = comma_inc;
                  if (comma_inc == LOCK_TGT) begin
                     state_nxt = ACTIVE;
                  end
               end else begin
                  comma_nxt = '0;
                  state_nxt = HUNT;
               end
            end
         end
         ACTIVE: begin
            word_upd = boundary;
         end
         default: begin
            state_nxt = HUNT;
            comma_nxt = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk8f or posedge reset) begin
      if (reset) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Shift register and counters. sh clears to 0 rather than COMMA so that no comma is seen right after reset.
   always_ff @(posedge clk8f or posedge reset) begin
      if (reset) begin
         sh        <= '0;
         bit_cnt   <= '0;
         comma_cnt <= '0;
      end else begin
         sh        <= {sh[DATA_W-2:0], data_serial};
         bit_cnt   <= bit_nxt;
         comma_cnt <= comma_nxt;
      end
   end

   // Registered word outputs. They load at each boundary in ACTIVE, and byte_strobe pulses for that one cycle.
   always_ff @(posedge clk8f or posedge reset) begin
      if (reset) begin
         data_out    <= '0;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
      end else begin
         byte_strobe <= word_upd;
         if (word_upd) begin
            data_out  <= sh;
            valid_out <= !is_comma;
         end
      end
   end

endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// Testbench for serial_to_parallel_sync.
// Checks every edge against a reference model based on word phase and edge index, plus directed checks.
// Inputs change on the falling edge, and outputs are sampled 1 time unit after the rising edge.
module tb_serial_to_parallel_sync;

   localparam int         LOCK_COUNT = 4;
   localparam logic [7:0] BC         = 8'hBC;

   logic       clk8f = 1'b0;
   logic       reset = 1'b1;
   logic       data_serial = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: history of link bits since reset plus lock bookkeeping
   bit         q[$];
   int         n;          // rising edges since reset release
   int         m_state;    // 0 hunting, 1 counting commas, 2 locked
   int         m_phase;    // edge index mod 8 at which words end
   int         m_cnt;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_strobe;

   // outputs captured on the first bit of the most recent byte
   logic [7:0] fd;
   logic       fv, fs, fa;
   int         sc;

   serial_to_parallel_sync dut (
      .clk8f       (clk8f),
      .reset       (reset),
      .data_serial (data_serial),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active)
   );

   always #5 clk8f = ~clk8f;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] cur_word();
      logic [7:0] w = 8'h00;
      foreach (q[i]) w = {w[6:0], q[i]};
      return w;
   endfunction

   task automatic model_reset();
      q.delete();
      n = 0; m_state = 0; m_phase = 0; m_cnt = 0;
      m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0;
   endtask

   task automatic model_step(input bit b);
      logic [7:0] w;
      w = cur_word();
      m_strobe = 1'b0;
      case (m_state)
         0: if (w == BC) begin
               m_phase = n % 8;
               m_cnt   = 1;
               m_state = (LOCK_COUNT == 1) ? 2 : 1;
            end
         1: if (n % 8 == m_phase) begin
               if (w == BC) begin
                  m_cnt++;
                  if (m_cnt == LOCK_COUNT) m_state = 2;
               end else begin
                  m_state = 0;
                  m_cnt   = 0;
               end
            end
         default: if (n % 8 == m_phase) begin
               m_data   = w;
               m_valid  = (w != BC);
               m_strobe = 1'b1;
            end
      endcase
      q.push_back(b);
      if (q.size() > 8) void'(q.pop_front());
      n++;
   endtask

   task automatic check_model();
      chk("data_out",    32'(data_out),    32'(m_data));
      chk("valid_out",   32'(valid_out),   32'(m_valid));
      chk("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
      chk("active",      32'(active),      32'(m_state == 2));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data"},   32'(data_out),    32'h0);
      chk({tag, "_valid"},  32'(valid_out),   32'h0);
      chk({tag, "_strobe"}, 32'(byte_strobe), 32'h0);
      chk({tag, "_active"}, 32'(active),      32'h0);
   endtask

   task automatic tick(input bit b);
      @(negedge clk8f);
      data_serial = b;
      @(posedge clk8f);
      model_step(b);
      #1;
      check_model();
   endtask

   task automatic send_byte(input logic [7:0] v);
      sc = 0;
      for (int i = 7; i >= 0; i--) begin
         tick(v[i]);
         if (i == 7) begin
            fd = data_out; fv = valid_out; fs = byte_strobe; fa = active;
         end
         if (byte_strobe) sc++;
      end
   endtask

   task automatic hold_reset(input int cycles);
      @(negedge clk8f);
      reset = 1'b1;
      #1;
      check_zero("rst_async");
      model_reset();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk8f);
         data_serial = ~data_serial;
         @(posedge clk8f);
         #1;
         check_zero("rst_hold");
      end
      @(negedge clk8f);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      check_zero("por");

      // 1: reset held with a toggling link, then an alternating pattern that never forms a comma
      hold_reset(10);
      for (int i = 0; i < 16; i++) tick(i[0]);
      chk("t1_active", 32'(active), 32'h0);

      // 2: three random bits, then four commas
      hold_reset(2);
      for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
      repeat (4) send_byte(BC);
      chk("t2_active_before", 32'(active), 32'h0);

      // 3: locked data flow
      send_byte(8'hA5);
      chk("t2_active_entry", 32'(fa), 32'h1);
      chk("t2_valid_entry",  32'(fv), 32'h0);
      chk("t2_strobe_entry", 32'(fs), 32'h0);
      send_byte(BC);
      chk("t3_a5_data",  32'(fd), 32'hA5);
      chk("t3_a5_valid", 32'(fv), 32'h1);
      chk("t3_a5_strb",  32'(fs), 32'h1);
      chk("t3_per_byte", 32'(sc), 32'h1);
      send_byte(8'h3C);
      chk("t3_bc_data",  32'(fd), 32'hBC);
      chk("t3_bc_valid", 32'(fv), 32'h0);
      chk("t3_per_byte", 32'(sc), 32'h1);
      send_byte(BC);
      chk("t3_3c_data",  32'(fd), 32'h3C);
      chk("t3_3c_valid", 32'(fv), 32'h1);
      chk("t3_per_byte", 32'(sc), 32'h1);

      // 4: a broken comma run falls back to hunting and needs four fresh commas
      hold_reset(2);
      send_byte(BC); send_byte(BC); send_byte(8'h12);
      send_byte(BC);
      chk("t4_active_12", 32'(fa), 32'h0);
      send_byte(BC); send_byte(BC);
      send_byte(BC);
      chk("t4_active_3", 32'(fa), 32'h0);
      send_byte(8'h55);
      chk("t4_active_4", 32'(fa), 32'h1);

      // 5: a comma straddling a byte boundary sets the alignment
      hold_reset(2);
      send_byte(8'h0B);
      repeat (3) send_byte(8'hCB);
      chk("t5_active_3", 32'(active), 32'h0);
      send_byte(8'hC0);
      chk("t5_active_4", 32'(active), 32'h1);

      // 6: a one-cycle reset pulse mid-word, then relock
      for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
      hold_reset(1);
      repeat (4) send_byte(BC);
      chk("t6_active_before", 32'(active), 32'h0);
      send_byte(8'h5A);
      chk("t6_active_after", 32'(fa), 32'h1);

      // random traffic while locked, with about a quarter of the words being commas
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) send_byte(BC);
         else send_byte(8'($urandom));
         chk("rnd_per_byte", 32'(sc), 32'h1);
      end

      // random bits while hunting, checked only against the model
      hold_reset(2);
      for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
